// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with occupancy, almost flags and error pulses
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   data_in      in   write data (WIDTH)
//   wr_en        in   write request
//   rd_en        in   read request
//   data_out     out  registered read data (WIDTH)
//   full         out  occupancy == DEPTH
//   empty        out  occupancy == 0
//   count        out  occupancy 0..DEPTH
//   almost_full  out  count >= ALMOST_FULL_TH
//   almost_empty out  count <= ALMOST_EMPTY_TH
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
module synchronous_fifo #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(ALMOST_FULL_TH);
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(ALMOST_EMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  // Equal addresses with differing wrap bits means the writer is a full lap ahead.
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                        (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

  // A simultaneous read frees a slot, so a write into a full FIFO still lands.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;

    if (wr_acc) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rptr_d     = rptr_q + PTR_W'(1);
      data_out_d = mem_q[rptr_q[ADDR_W-1:0]];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared on reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - self-checking bench for synchronous_fifo
module tb_synchronous_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [4:0]       count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  synchronous_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    bit       rst;
    bit       wr;
    bit       rd;
    bit [7:0] din;
    int       exp_cnt;
    bit       exp_ovf;
    bit       exp_unf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] exp_dout = 8'h00;
  int         total = 0;
  int         bad   = 0;
  int         step_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step%0d %s: got=%0h want=%0h", step_no, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit w, bit rd, bit [7:0] d, int c, bit o, bit u);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = d;
    v.exp_cnt = c; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  // Drive one cycle, advance the reference queue, then compare every output.
  // With use_model set the count/pulse expectations come from the queue instead of v.
  task automatic step(input vec_t v, input bit use_model);
    bit rd_ok, wr_ok;
    int c;
    bit o, u;
    @(negedge clk);
    rst = v.rst; wr_en = v.wr; rd_en = v.rd; data_in = v.din;
    rd_ok = 1'b0; wr_ok = 1'b0;
    if (v.rst) begin
      sb.delete();
      exp_dout = 8'h00;
    end else begin
      rd_ok = v.rd && (sb.size() > 0);
      wr_ok = v.wr && ((sb.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout = sb.pop_front();
      if (wr_ok) sb.push_back(v.din);
    end
    if (use_model) begin
      c = sb.size();
      o = !v.rst && v.wr && !wr_ok;
      u = !v.rst && v.rd && !rd_ok;
    end else begin
      c = v.exp_cnt;
      o = v.exp_ovf;
      u = v.exp_unf;
    end
    @(posedge clk);
    #1;
    step_no++;
    check("count",        32'(count),        32'(c));
    check("empty",        32'(empty),        32'(c == 0));
    check("full",         32'(full),         32'(c == DEPTH));
    check("almost_full",  32'(almost_full),  32'(c >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(c <= 2));
    check("overflow",     32'(overflow),     32'(o));
    check("underflow",    32'(underflow),    32'(u));
    check("data_out",     32'(data_out),     32'(exp_dout));
  endtask

  initial begin
    // Directed table: reset, single word, fill/overflow, drain/underflow, streaming.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hAA, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 1, 0, 8'(i), i + 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hFF, 16, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 16, 0, 0));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 0, 1, 8'h00, 15 - i, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 8'(8'h10 + i), i + 1, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 8'(8'h20 + i), 5, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 8'h00, 4 - i, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b0);

    // Empty with both enables: write lands, read is rejected, no fall-through.
    step(mk(0, 1, 1, 8'h55, 1, 0, 1), 1'b0);
    step(mk(0, 0, 1, 8'h00, 0, 0, 0), 1'b0);

    // Full with both enables: both accepted, count stays at DEPTH, order kept.
    for (int i = 0; i < 16; i++) step(mk(0, 1, 0, 8'(8'h40 + i), i + 1, 0, 0), 1'b0);
    step(mk(0, 1, 1, 8'h77, 16, 0, 0), 1'b0);
    for (int i = 0; i < 16; i++) step(mk(0, 0, 1, 8'h00, 15 - i, 0, 0), 1'b0);

    // Random traffic well past two pointer laps, checked against the queue.
    for (int i = 0; i < 300; i++) begin
      step(mk(0, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
              8'($urandom), 0, 0, 0), 1'b1);
    end

    // Reset mid-operation with seven words stored and both enables high.
    step(mk(1, 0, 0, 8'h00, 0, 0, 0), 1'b0);
    for (int i = 0; i < 7; i++) step(mk(0, 1, 0, 8'(8'h60 + i), i + 1, 0, 0), 1'b0);
    step(mk(0, 0, 1, 8'h00, 6, 0, 0), 1'b0);
    step(mk(0, 1, 0, 8'h67, 7, 0, 0), 1'b0);
    step(mk(1, 1, 1, 8'h99, 0, 0, 0), 1'b0);
    step(mk(0, 1, 0, 8'h3C, 1, 0, 0), 1'b0);
    step(mk(0, 0, 1, 8'h00, 0, 0, 0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
